// File: rtl/serial_ripple_adder_if.sv
// serial_ripple_adder_if: operand/result bundle of the bit-serial adder.
// master drives start/a/b/cin; slave returns sum/cout/busy/done (+ovf when
// SERIAL_RIPPLE_ADDER_OVF_EN is defined).
interface serial_ripple_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_RIPPLE_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  sum, cout, busy, done, ovf
  );
  modport slave (
    input  start, a, b, cin,
    output sum, cout, busy, done, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  sum, cout, busy, done
  );
  modport slave (
    input  start, a, b, cin,
    output sum, cout, busy, done
  );
`endif
endinterface

// File: rtl/serial_ripple_adder.sv
// serial_ripple_adder: one full-adder slice (two half-adder cells) adds
// WIDTH-bit a+b+cin LSB first, one bit per clock, over WIDTH ADD cycles.
// Ports: clk, rst (sync, active-high), bus (slave: start/a/b/cin in,
// sum/cout/busy/done out). Macro SERIAL_RIPPLE_ADDER_OVF_EN adds bus.ovf.
module serial_ripple_adder_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_ripple_adder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic p;
  logic g1;
  logic bit_s;
  logic g2;
  logic carry_nx;
  logic last;

  serial_ripple_adder_ha u_ha1 (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .s (p),
    .c (g1)
  );

  serial_ripple_adder_ha u_ha2 (
    .x (p),
    .y (carry),
    .s (bit_s),
    .c (g2)
  );

  assign carry_nx = g1 | g2;
  assign last     = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_RIPPLE_ADDER_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_RIPPLE_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= ADD;
            busy_q <= 1'b1;
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            acc    <= '0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        ADD: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          acc   <= {bit_s, acc[WIDTH-1:1]};
          carry <= carry_nx;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= {bit_s, acc[WIDTH-1:1]};
            cout_q <= carry_nx;
`ifdef SERIAL_RIPPLE_ADDER_OVF_EN
            // carry here is the carry into the MSB
            ovf_q  <= carry ^ carry_nx;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
